// File: rtl/control_pkg.sv
// Shared types and helpers for the pipeline sequencer: fetch/dmem FSM states and PC arithmetic.
package control_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    F_REQ,
    F_WAIT,
    F_HOLD,
    F_DISCARD
  } fetch_state_e;

  typedef enum logic {
    D_IDLE,
    D_WAIT
  } dmem_state_e;

  // Sequential successor; wraps at 2^32, no alignment check.
  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_seq.sv
// Fetch sequencer: owns the PC, the single outstanding imem transaction and the
// one-entry hold buffer for responses IF/ID cannot take yet.
module fetch_seq
  import control_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  input  logic        redirect,
  input  logic [31:0] target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_valid
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] hold_q, hold_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= F_REQ;
      pc_q    <= RESET_PC;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    hold_d    = hold_q;
    imem_req  = 1'b0;
    imem_addr = rst_n ? pc_q : RESET_PC;
    if_valid  = 1'b0;
    if_instr  = hold_q;
    if_pc     = pc_q;
    if (rst_n) begin
      unique case (state_q)
        F_REQ: begin
          imem_req = 1'b1;
          if (redirect) begin
            pc_d    = target;
            state_d = imem_gnt ? F_DISCARD : F_REQ;
          end else if (imem_gnt) begin
            state_d = F_WAIT;
          end
        end
        F_WAIT: begin
          // A redirect retires the in-flight fetch; a same-cycle response is simply dropped.
          if (redirect) begin
            pc_d    = target;
            state_d = imem_rvalid ? F_REQ : F_DISCARD;
          end else if (imem_rvalid) begin
            if (advance) begin
              if_valid = 1'b1;
              if_instr = imem_rdata;
              pc_d     = pc_plus4(pc_q);
              state_d  = F_REQ;
            end else begin
              hold_d  = imem_rdata;
              state_d = F_HOLD;
            end
          end
        end
        F_HOLD: begin
          if (redirect) begin
            pc_d    = target;
            state_d = F_REQ;
          end else begin
            if_valid = 1'b1;
            if (advance) begin
              pc_d    = pc_plus4(pc_q);
              state_d = F_REQ;
            end
          end
        end
        F_DISCARD: begin
          if (redirect) begin
            pc_d = target;
          end
          if (imem_rvalid) begin
            state_d = F_REQ;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer top: dmem handshake tracking, freeze generation, merge of hazard
// requests into per-stage enables/flushes, and the saturating stall counter.
module pipeline_ctrl
  import control_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hz_stall_pc,
  input  logic        hz_stall_ifid,
  input  logic        hz_flush_ifid,
  input  logic        hz_flush_idex,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_valid,
  input  logic        mem_req_valid,
  input  logic        mem_is_load,
  output logic        dmem_req,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  output logic        en_ifid,
  output logic        en_idex,
  output logic        en_exmem,
  output logic        en_memwb,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic [31:0] stall_cycles
);

  dmem_state_e dstate_q, dstate_d;
  logic        freeze;
  logic        redirect;
  logic        advance;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dstate_q     <= D_IDLE;
      stall_cycles <= '0;
    end else begin
      dstate_q <= dstate_d;
      if ((freeze || hz_stall_pc) && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + XLEN'(1);
      end
    end
  end

  // Freeze overrides every hazard request; EX is held so the hazard unit repeats them.
  always_comb begin
    dstate_d   = dstate_q;
    freeze     = 1'b0;
    dmem_req   = 1'b0;
    en_ifid    = 1'b0;
    en_idex    = 1'b0;
    en_exmem   = 1'b0;
    en_memwb   = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    redirect   = 1'b0;
    advance    = 1'b0;
    if (rst_n) begin
      unique case (dstate_q)
        D_IDLE: begin
          dmem_req = mem_req_valid;
          freeze   = mem_req_valid && !dmem_gnt;
          if (mem_req_valid && dmem_gnt && mem_is_load) begin
            dstate_d = D_WAIT;
          end
        end
        D_WAIT: begin
          freeze = !dmem_rvalid;
          if (dmem_rvalid) begin
            dstate_d = D_IDLE;
          end
        end
      endcase
      if (!freeze) begin
        en_idex    = 1'b1;
        en_exmem   = 1'b1;
        en_memwb   = 1'b1;
        en_ifid    = !hz_stall_ifid;
        flush_ifid = hz_flush_ifid;
        flush_idex = hz_flush_idex;
      end
      redirect = hz_flush_ifid && !freeze;
      advance  = en_ifid && !redirect && !hz_stall_pc;
    end
  end

  fetch_seq #(
    .RESET_PC(RESET_PC)
  ) u_fetch (
    .clk        (clk),
    .rst_n      (rst_n),
    .advance    (advance),
    .redirect   (redirect),
    .target     (redirect_target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_valid   (if_valid)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized bench for pipeline_ctrl: bench-side imem/dmem responders, an architectural
// program-order scoreboard for delivered instructions, and a per-cycle enable/counter model.
module tb_pipeline_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hz_stall_pc, hz_stall_ifid, hz_flush_ifid, hz_flush_idex;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] if_instr, if_pc;
  logic        if_valid;
  logic        mem_req_valid, mem_is_load;
  logic        dmem_req, dmem_gnt, dmem_rvalid;
  logic        en_ifid, en_idex, en_exmem, en_memwb;
  logic        flush_ifid, flush_idex;
  logic [31:0] stall_cycles;

  always #5 clk = ~clk;

  pipeline_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .hz_stall_pc(hz_stall_pc), .hz_stall_ifid(hz_stall_ifid),
    .hz_flush_ifid(hz_flush_ifid), .hz_flush_idex(hz_flush_idex),
    .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
    .mem_req_valid(mem_req_valid), .mem_is_load(mem_is_load),
    .dmem_req(dmem_req), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .en_ifid(en_ifid), .en_idex(en_idex), .en_exmem(en_exmem), .en_memwb(en_memwb),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .stall_cycles(stall_cycles)
  );

  int errors = 0;
  int checks = 0;

  // Scoreboard: PCs the program must deliver next, in order.
  logic [31:0] exp_q[$];

  // Bench-side memory and model state.
  bit          load_busy = 0;
  int          dwait = 0;
  bit          frozen_last = 0;
  bit          i_out = 0, i_stale = 0;
  logic [31:0] i_addr = '0;
  int          icnt = 0;
  logic [31:0] model_cnt = '0;
  bit          cnt_valid = 0;
  int          phase = 0;
  int          delivered = 0;
  bit          redir_pend = 0;
  logic [31:0] redir_tgt = '0;
  bit          prev_pending = 0;
  logic [31:0] prev_addr = '0;
  bit          was_running = 0;
  int          cyc_since_rst = 0;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic bit freeze_m();
    return (!load_busy && mem_req_valid && !dmem_gnt) || (load_busy && !dmem_rvalid);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs; random_mode enables hazards and dmem traffic.
  task automatic drive(input bit random_mode);
    bit stall;
    imem_rvalid = i_out && (icnt == 0);
    imem_rdata  = imem_rvalid ? mem_fn(i_addr) : $urandom;
    imem_gnt    = !i_out && (phase == 0 || $urandom_range(0, 99) < 55);
    dmem_rvalid = load_busy && (dwait == 0);
    if (!frozen_last) begin
      mem_req_valid = random_mode && ($urandom_range(0, 99) < 30);
      mem_is_load   = 1'($urandom_range(0, 1));
    end
    dmem_gnt = !load_busy && mem_req_valid && ($urandom_range(0, 99) < 60);
    if (random_mode && rst_n) begin
      if (!redir_pend && $urandom_range(0, 99) < 8) begin
        redir_pend = 1;
        redir_tgt  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF4
                                                 : 32'($urandom_range(0, 1023)) << 2;
      end
      hz_flush_ifid   = redir_pend;
      redirect_target = redir_pend ? redir_tgt : $urandom;
      hz_flush_idex   = redir_pend || ($urandom_range(0, 99) < 5);
      stall           = !redir_pend && ($urandom_range(0, 99) < 12);
      hz_stall_pc     = stall;
      hz_stall_ifid   = stall;
    end else begin
      hz_flush_ifid   = 0;
      hz_flush_idex   = 0;
      hz_stall_pc     = 0;
      hz_stall_ifid   = 0;
      redirect_target = $urandom;
    end
    // An unfrozen redirect restarts the program stream at the target.
    if (rst_n && hz_flush_ifid && !freeze_m()) begin
      exp_q.delete();
      exp_q.push_back(redirect_target);
      redir_pend = 0;
    end
  endtask

  task automatic cycle(input bit r, input bit random_mode);
    @(posedge clk);
    #1;
    rst_n = r;
    if (!r) begin
      exp_q.delete();
      exp_q.push_back(RST_PC);
      redir_pend = 0;
    end
    drive(random_mode);
  endtask

  // Monitor: compare mid-cycle, then advance the model across the coming edge.
  always @(negedge clk) begin
    bit fz;
    fz = freeze_m();
    if (!rst_n) begin
      check("rst_gated", 32'({imem_req, dmem_req, if_valid, en_ifid, en_idex, en_exmem,
                              en_memwb, flush_ifid, flush_idex}), 32'h0);
      check("rst_addr", imem_addr, RST_PC);
      model_cnt     = '0;
      cnt_valid     = 1;
      load_busy     = 0;
      frozen_last   = 0;
      prev_pending  = 0;
      was_running   = 0;
      cyc_since_rst = 0;
      if (i_out) i_stale = 1;
    end else begin
      if (!was_running) begin
        check("first_req", 32'(imem_req), 32'h1);
        check("first_addr", imem_addr, RST_PC);
      end
      check("enables", 32'({en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex}),
            32'({!fz && !hz_stall_ifid, !fz, !fz, !fz, !fz && hz_flush_ifid, !fz && hz_flush_idex}));
      check("dmem_req", 32'(dmem_req), 32'(!load_busy && mem_req_valid));
      if (cnt_valid) check("stall_cycles", stall_cycles, model_cnt);
      if (i_out && !i_stale) check("one_outstanding", 32'(imem_req), 32'h0);
      if (prev_pending && imem_req) check("addr_stable", imem_addr, prev_addr);
      if (phase == 0 && cyc_since_rst < 8)
        check("zw_if_valid", 32'(if_valid), 32'(cyc_since_rst % 2));
      if (if_valid && en_ifid) begin
        if (exp_q.size() == 0) begin
          check("deliver_unexpected", if_pc, 32'hDEAD_DEAD);
        end else begin
          logic [31:0] epc;
          epc = exp_q.pop_front();
          check("if_pc", if_pc, epc);
          check("if_instr", if_instr, mem_fn(epc));
          exp_q.push_back(epc + 32'd4);
          delivered++;
        end
      end
      prev_pending = imem_req && !imem_gnt && !(hz_flush_ifid && !fz);
      prev_addr    = imem_addr;
      if (!load_busy && mem_req_valid && dmem_gnt && mem_is_load) begin
        load_busy = 1;
        dwait     = $urandom_range(0, 4);
      end else if (load_busy) begin
        if (dmem_rvalid) load_busy = 0;
        else if (dwait > 0) dwait--;
      end
      frozen_last = fz;
      if ((fz || hz_stall_pc) && model_cnt != 32'hFFFF_FFFF) model_cnt = model_cnt + 32'd1;
      was_running = 1;
      cyc_since_rst++;
    end
    if (i_out) begin
      if (imem_rvalid) begin
        i_out   = 0;
        i_stale = 0;
      end else if (icnt > 0) begin
        icnt--;
      end
    end
    if (rst_n && imem_req && imem_gnt) begin
      i_out   = 1;
      i_stale = 0;
      i_addr  = imem_addr;
      icnt    = (phase == 0) ? 0 : $urandom_range(0, 3);
    end
  end

  initial begin
    rst_n = 0;
    hz_stall_pc = 0; hz_stall_ifid = 0; hz_flush_ifid = 0; hz_flush_idex = 0;
    redirect_target = '0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    mem_req_valid = 0; mem_is_load = 0; dmem_gnt = 0; dmem_rvalid = 0;
    exp_q.push_back(RST_PC);

    repeat (3) cycle(0, 0);
    repeat (10) cycle(1, 0);
    phase = 1;
    repeat (1500) cycle(1, 1);
    // Reset in the middle of traffic; any stale imem response must be ignored.
    repeat (2) cycle(0, 0);
    repeat (1500) cycle(1, 1);

    // Counter saturation from a preloaded near-max value.
    @(posedge clk);
    #1;
    force dut.stall_cycles = 32'hFFFF_FFFE;
    model_cnt = 32'hFFFF_FFFE;
    drive(0);
    hz_stall_pc = 1; hz_stall_ifid = 1;
    @(negedge clk);
    #1;
    release dut.stall_cycles;
    repeat (3) begin
      cycle(1, 0);
      hz_stall_pc = 1; hz_stall_ifid = 1;
    end
    @(negedge clk);
    #2;
    check("stall_sat", stall_cycles, 32'hFFFF_FFFF);
    cycle(1, 0);
    @(negedge clk);
    #2;
    check("liveness", 32'(delivered > 200), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
